// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS front end: PC-select encodings,
// fetch FSM states and reset constants.
package mips_pkg;

  localparam logic [1:0]  PC_SEQ  = 2'b00;
  localparam logic [1:0]  PC_JUMP = 2'b01;
  localparam logic [1:0]  PC_BR   = 2'b10;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EXEC,
    S_HALT
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, j, jr and PC-relative branch.
module next_pc_calc
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [25:0]       ir_idx_i,
  input  logic [1:0]        pcsrc_i,
  input  logic              jsrc_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic [ADDR_W-1:0] next_pc_o
);

  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] jmp_tgt;

  assign pc_plus4_o = pc_i + ADDR_W'(4);
  // Branch offset is the low 16 bits of the instruction, sign-extended, in words.
  assign br_off     = {{14{ir_idx_i[15]}}, ir_idx_i[15:0], 2'b00};
  assign jmp_tgt    = {pc_plus4_o[31:28], ir_idx_i, 2'b00};

  always_comb begin
    next_pc_o = pc_plus4_o;
    case (pcsrc_i)
      PC_JUMP: next_pc_o = jsrc_i ? jr_target_i : jmp_tgt;
      PC_BR:   next_pc_o = pc_plus4_o + br_off;
      default: next_pc_o = pc_plus4_o;
    endcase
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: SRAM request/response FSM, held instruction
// register, PC update on commit and sticky misaligned-PC halt.
module inst_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              inst_sram_en,
  output logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [31:0]       inst_sram_rdata,
  input  logic              inst_sram_rvalid,
  input  logic              commit,
  input  logic [1:0]        PCSrc,
  input  logic              JSrc,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [31:0]       ir,
  output logic [5:0]        op,
  output logic [5:0]        func,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              ir_valid,
  output logic              addr_err,
  output logic [31:0]       inst_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] next_pc;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_npc (
    .pc_i        (pc_q),
    .ir_idx_i    (ir_q[25:0]),
    .pcsrc_i     (PCSrc),
    .jsrc_i      (JSrc),
    .jr_target_i (jr_target),
    .pc_plus4_o  (pc_plus4),
    .next_pc_o   (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_WORD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (inst_sram_rvalid) begin
          ir_d    = inst_sram_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (commit) begin
          pc_d    = next_pc;
          cnt_d   = cnt_q + 32'd1;
          // A misaligned target parks the unit until reset; pc keeps the bad address.
          state_d = (next_pc[1:0] != 2'b00) ? S_HALT : S_REQ;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign inst_sram_en   = (state_q == S_REQ);
  assign inst_sram_addr = pc_q;
  assign ir             = ir_q;
  assign op             = ir_q[31:26];
  assign func           = ir_q[5:0];
  assign pc             = pc_q;
  assign ir_valid       = (state_q == S_EXEC);
  assign addr_err       = (state_q == S_HALT);
  assign inst_count     = cnt_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: fetch handshake, PC update paths,
// ignored events, misaligned halt and reset mid-fetch.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_rvalid;
  logic        commit;
  logic [1:0]  PCSrc;
  logic        JSrc;
  logic [31:0] jr_target;
  logic [31:0] ir;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ir_valid;
  logic        addr_err;
  logic [31:0] inst_count;

  int checks = 0;
  int errors = 0;

  inst_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .inst_sram_en     (inst_sram_en),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_rdata  (inst_sram_rdata),
    .inst_sram_rvalid (inst_sram_rvalid),
    .commit           (commit),
    .PCSrc            (PCSrc),
    .JSrc             (JSrc),
    .jr_target        (jr_target),
    .ir               (ir),
    .op               (op),
    .func             (func),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .ir_valid         (ir_valid),
    .addr_err         (addr_err),
    .inst_count       (inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From S_REQ: respond on the next cycle, then commit with the given controls.
  task automatic run_insn(input logic [31:0] word, input logic [1:0] src,
                          input logic js, input logic [31:0] jrt);
    tick();
    inst_sram_rdata  = word;
    inst_sram_rvalid = 1'b1;
    tick();
    inst_sram_rvalid = 1'b0;
    commit    = 1'b1;
    PCSrc     = src;
    JSrc      = js;
    jr_target = jrt;
    tick();
    commit = 1'b0;
    PCSrc  = 2'b00;
    JSrc   = 1'b0;
  endtask

  initial begin
    int en_seen;
    rst = 1'b1;
    inst_sram_rdata  = '0;
    inst_sram_rvalid = 1'b0;
    commit    = 1'b0;
    PCSrc     = 2'b00;
    JSrc      = 1'b0;
    jr_target = '0;
    tick();
    tick();
    chk("rst_pc",    pc, 32'hbfc0_0000);
    chk("rst_ir",    ir, 32'h0);
    chk("rst_en",    {31'b0, inst_sram_en}, 32'd0);
    chk("rst_vld",   {31'b0, ir_valid}, 32'd0);
    chk("rst_err",   {31'b0, addr_err}, 32'd0);
    chk("rst_cnt",   inst_count, 32'd0);
    rst = 1'b0;
    tick();                                   // S_IDLE -> S_REQ
    chk("req_en",    {31'b0, inst_sram_en}, 32'd1);
    chk("req_addr",  inst_sram_addr, 32'hbfc0_0000);
    tick();                                   // S_WAIT
    chk("wait_en",   {31'b0, inst_sram_en}, 32'd0);
    tick();                                   // rvalid two cycles after en
    inst_sram_rdata  = 32'h2408_0005;
    inst_sram_rvalid = 1'b1;
    tick();                                   // S_EXEC
    inst_sram_rvalid = 1'b0;
    chk("ir_load",   ir, 32'h2408_0005);
    chk("op",        {26'b0, op}, 32'h09);
    chk("func",      {26'b0, func}, 32'h05);
    chk("ir_valid",  {31'b0, ir_valid}, 32'd1);
    chk("pc4",       pc_plus4, 32'hbfc0_0004);
    // Spurious response while executing must not disturb ir.
    inst_sram_rdata  = 32'hffff_ffff;
    inst_sram_rvalid = 1'b1;
    tick();
    inst_sram_rvalid = 1'b0;
    chk("spur_ir",   ir, 32'h2408_0005);
    chk("spur_vld",  {31'b0, ir_valid}, 32'd1);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("seq_en",    {31'b0, inst_sram_en}, 32'd1);
    chk("seq_addr",  inst_sram_addr, 32'hbfc0_0004);
    chk("seq_cnt",   inst_count, 32'd1);
    chk("seq_vld",   {31'b0, ir_valid}, 32'd0);
    // Commit while waiting is ignored.
    tick();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("wcmt_pc",   pc, 32'hbfc0_0004);
    chk("wcmt_cnt",  inst_count, 32'd1);
    inst_sram_rdata  = 32'h0;
    inst_sram_rvalid = 1'b1;
    tick();
    inst_sram_rvalid = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("pc_08",     inst_sram_addr, 32'hbfc0_0008);
    run_insn(32'h0, 2'b00, 1'b0, 32'h0);
    run_insn(32'h0, 2'b00, 1'b0, 32'h0);
    chk("pc_10",     pc, 32'hbfc0_0010);
    // beq offset -2: bfc00014 - 8
    run_insn(32'h1000_fffe, 2'b10, 1'b0, 32'h0);
    chk("br_addr",   inst_sram_addr, 32'hbfc0_000c);
    chk("br_en",     {31'b0, inst_sram_en}, 32'd1);
    chk("br_cnt",    inst_count, 32'd5);
    for (int i = 0; i < 5; i++) run_insn(32'h0, 2'b11, 1'b1, 32'h1234_5678);
    chk("pc_20",     pc, 32'hbfc0_0020);
    chk("cnt_10",    inst_count, 32'd10);
    run_insn(32'h0810_0040, 2'b01, 1'b0, 32'h0);
    chk("j_addr",    inst_sram_addr, 32'hb040_0100);
    // jr to a misaligned target halts.
    run_insn(32'h03e0_0008, 2'b01, 1'b1, 32'h8000_1002);
    chk("jr_err",    {31'b0, addr_err}, 32'd1);
    chk("jr_pc",     pc, 32'h8000_1002);
    chk("jr_cnt",    inst_count, 32'd12);
    chk("jr_vld",    {31'b0, ir_valid}, 32'd0);
    en_seen = 0;
    commit = 1'b1;
    inst_sram_rvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (inst_sram_en) en_seen++;
      tick();
    end
    commit = 1'b0;
    inst_sram_rvalid = 1'b0;
    chk("halt_en",   en_seen, 32'd0);
    chk("halt_pc",   pc, 32'h8000_1002);
    chk("halt_cnt",  inst_count, 32'd12);
    chk("halt_err",  {31'b0, addr_err}, 32'd1);
    // Reset clears halt; then reset again while waiting for a response.
    rst = 1'b1;
    #1;
    chk("rst2_err",  {31'b0, addr_err}, 32'd0);
    chk("rst2_pc",   pc, 32'hbfc0_0000);
    tick();
    rst = 1'b0;
    tick();
    tick();                                   // S_WAIT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    inst_sram_rdata  = 32'hdead_beef;
    inst_sram_rvalid = 1'b1;
    tick();                                   // S_REQ, response dropped
    inst_sram_rvalid = 1'b0;
    chk("drop_en",   {31'b0, inst_sram_en}, 32'd1);
    chk("drop_addr", inst_sram_addr, 32'hbfc0_0000);
    chk("drop_ir",   ir, 32'h0);
    chk("drop_vld",  {31'b0, ir_valid}, 32'd0);
    // pc_plus4 wraps at the top of the address space.
    run_insn(32'h03e0_0008, 2'b01, 1'b1, 32'hffff_fffc);
    chk("wrap_pc",   pc, 32'hffff_fffc);
    chk("wrap_pc4",  pc_plus4, 32'h0);
    run_insn(32'h0, 2'b00, 1'b0, 32'h0);
    chk("wrap_addr", inst_sram_addr, 32'h0);
    chk("wrap_err",  {31'b0, addr_err}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
